// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sharing of one multiplier among N requesters
module mult_arbiter #(
  parameter int WIDTH   = 8,
  parameter int N       = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*WIDTH-1:0]   op_a,
  input  logic [N*WIDTH-1:0]   op_b,
  output logic [N-1:0]         gnt,
  output logic [N-1:0]         rsp_valid,
  output logic [2*WIDTH-1:0]   rsp_data,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 mul_en,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  input  logic [2*WIDTH-1:0]   mul_out,
  input  logic                 mul_done
);
  localparam int PW = $clog2(N);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;
  state_t              r_state, w_next;
  logic [PW-1:0]       r_ptr, r_win, w_win;
  logic [CW-1:0]       r_cnt;
  logic [N-1:0]        r_gnt, r_valid;
  logic [2*WIDTH-1:0]  r_data;
  logic                r_err, r_en, w_fire;
  logic [WIDTH-1:0]    r_a, r_b;
  // scan downwards so the requester closest after r_ptr is written last and wins
  always_comb begin
    w_win = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[(int'(r_ptr) + i) % N]) w_win = PW'((int'(r_ptr) + i) % N);
  end
  assign w_fire = (TIMEOUT != 0) && (r_cnt == LAST);
  always_comb begin
    w_next = r_state == IDLE ? (|req ? RUN : IDLE)
           : r_state == RUN  ? ((mul_done || w_fire) ? RESP : RUN)
           : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= '0;
      r_win   <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_valid <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
      r_en    <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
    end else if (r_state == IDLE) begin
      if (|req) begin
        r_win <= w_win;
        r_gnt <= N'(1) << w_win;
        r_en  <= 1'b1;
        r_a   <= op_a[int'(w_win)*WIDTH +: WIDTH];
        r_b   <= op_b[int'(w_win)*WIDTH +: WIDTH];
      end
    end else if (r_state == RUN) begin
      r_cnt <= r_cnt + 1'b1;
      if (mul_done || w_fire) begin
        r_en    <= 1'b0;
        r_valid <= r_gnt;
        r_err   <= !mul_done;
        r_data  <= mul_done ? mul_out : '0;
      end
    end else begin
      r_gnt   <= '0;
      r_valid <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_ptr   <= r_win == PW'(N - 1) ? '0 : r_win + 1'b1;
    end
  end
  assign gnt       = r_gnt;
  assign rsp_valid = r_valid;
  assign rsp_data  = r_data;
  assign rsp_err   = r_err;
  assign busy      = r_state != IDLE;
  assign mul_en    = r_en;
  assign mul_a     = r_a;
  assign mul_b     = r_b;
endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: randomized requesters and a latency-programmable multiplier stub
module tb_mult_arbiter;
  localparam int W = 8, N = 4, TO = 16;
  logic clk = 0, rst = 1, scr = 0;
  logic [N-1:0] pend = '0, pulse = '0, gnt, rsp_valid;
  logic [N*W-1:0] op_a, op_b, sa = '0, sb = '0;
  logic [W-1:0] oa [N], ob [N];
  logic [2*W-1:0] rsp_data, mul_out;
  logic rsp_err, busy, mul_en, mul_done;
  logic [W-1:0] mul_a, mul_b;
  int lat = 0, mcnt = 0, ptr = 0, total = 0, bad = 0;

  mult_arbiter #(.WIDTH(W), .N(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(pend | pulse), .op_a(op_a), .op_b(op_b),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b),
    .mul_out(mul_out), .mul_done(mul_done)
  );

  always #5 clk = ~clk;
  always_comb begin
    op_a = sa;
    op_b = sb;
    if (!scr)
      for (int i = 0; i < N; i++) begin
        op_a[i*W +: W] = oa[i];
        op_b[i*W +: W] = ob[i];
      end
  end
  always @(posedge clk) mcnt <= mul_en ? mcnt + 1 : 0;
  assign mul_done = mul_en && mcnt == lat;
  assign mul_out  = mul_done ? 16'(mul_a) * 16'(mul_b) : 16'hdead;

  task chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] p);
    for (int i = 0; i < N; i++)
      if (p[(ptr + i) % N]) return (ptr + i) % N;
    return -1;
  endfunction

  task do_op(input int l, input int abort_at);
    int w, n, en_cycles;
    logic [2*W-1:0] exp;
    logic e;
    w = pick(pend);
    lat = l;
    e = l >= TO;
    exp = e ? 16'd0 : 16'(oa[w]) * 16'(ob[w]);
    en_cycles = (l + 1 < TO) ? l + 1 : TO;
    @(negedge clk);
    chk("grant", gnt, 1 << w);
    chk("mul_a", mul_a, oa[w]);
    chk("mul_b", mul_b, ob[w]);
    chk("busy", busy, 1);
    sa = $urandom;
    sb = $urandom;
    scr = 1;
    pulse = ~pend & 4'($urandom);
    n = 0;
    while (!rsp_valid && n < 200) begin
      if (abort_at != 0 && n == abort_at) begin
        rst = 1;
        @(negedge clk);
        rst = 0;
        pend = '0;
        pulse = '0;
        scr = 0;
        ptr = 0;
        chk("abort_out", {mul_en, busy, gnt, rsp_valid}, 0);
        @(negedge clk);
        chk("abort_idle", {mul_en, busy, gnt, rsp_valid}, 0);
        return;
      end
      chk("run_en", mul_en, 1);
      chk("run_gnt", gnt, 1 << w);
      n++;
      @(negedge clk);
    end
    chk("rsp_valid", rsp_valid, 1 << w);
    chk("rsp_data", rsp_data, exp);
    chk("rsp_err", rsp_err, e);
    chk("resp_gnt", gnt, 1 << w);
    chk("resp_en", mul_en, 0);
    chk("run_len", n, en_cycles);
    pend[w] = 0;
    pulse = '0;
    scr = 0;
    ptr = (w + 1) % N;
    @(negedge clk);
    chk("idle_ctl", {busy, mul_en, rsp_valid, gnt, rsp_err}, 0);
    chk("idle_dat", {rsp_data, mul_a, mul_b}, 0);
  endtask

  task pulse_rst;
    rst = 1;
    @(negedge clk);
    rst = 0;
    ptr = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      oa[i] = '0;
      ob[i] = '0;
    end
    repeat (2) @(negedge clk);
    chk("reset_ctl", {busy, mul_en, rsp_valid, gnt, rsp_err}, 0);
    chk("reset_dat", {rsp_data, mul_a, mul_b}, 0);
    rst = 0;
    oa[0] = 5; ob[0] = 10; pend = 4'b0001;
    do_op(3, 0);
    pulse_rst();
    oa[1] = 48; ob[1] = 55; oa[3] = 255; ob[3] = 255; pend = 4'b1010;
    do_op(2, 0);
    do_op(7, 0);
    pulse_rst();
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < N; i++) if (!pend[i]) begin oa[i] = 8'($urandom); ob[i] = 8'($urandom); end
      pend = 4'hf;
      do_op($urandom_range(0, 10), 0);
    end
    pend = '0;
    @(negedge clk);
    oa[0] = 200; ob[0] = 3; pend = 4'b0001;
    do_op(TO - 1, 0);
    pend = 4'b0001;
    do_op(1000, 0);
    pend = 4'b0010;
    do_op(1000, 3);
    oa[2] = 7; ob[2] = 9; pend = 4'b0100;
    do_op(2, 0);
    for (int k = 0; k < 150; k++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1;
          oa[i] = 8'($urandom);
          ob[i] = 8'($urandom);
        end
      if ($urandom_range(0, 7) == 0) pend[$urandom_range(0, N - 1)] = 0;
      if (pend == 0) begin
        @(negedge clk);
        chk("idle_noreq", {busy, gnt, mul_en}, 0);
      end else if ($urandom_range(0, 19) == 0)
        do_op($urandom_range(6, 20), $urandom_range(1, 4));
      else
        do_op($urandom_range(0, 20), 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
